alu_byte_sequencer: RTL and testbench
=====================================

ALU_BYTE_SEQUENCER -- requirements
Module: alu_byte_sequencer

Interface
- REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, giving the idle-host cycles before abort; it is used only with ALU_SEQ_TIMEOUT_EN.
- REQ-002 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
- REQ-003 Port rst, input, 1 bit: reset, asynchronous, active-high.
- REQ-004 Port ena, input, 1 bit: enable; when low, all registers SHALL hold.
- REQ-005 Port ui_in, input, 8 bits: host data byte.
- REQ-006 Port uio_in, input, 8 bits: bit 0 is strobe (byte valid) and bit 1 is ack (result taken); other bits are ignored.
- REQ-007 Port uo_out, output, 8 bits: registered result byte.
- REQ-008 Port uio_out, output, 8 bits: bit 0 rdy (byte accepted next), bit 1 res_valid, bits 3:2 state code, bit 4 timeout flag; other bits are 0.
- REQ-009 Port uio_oe, output, 8 bits: SHALL be constant 8'b0001_1111.
- REQ-010 Ports alu_a and alu_b, outputs, 8 bits each, and alu_s, output, 2 bits: registered operands and selector driven to the ALU.
- REQ-011 Port alu_result, input, 8 bits: combinational ALU result.

Function
- REQ-012 strobe and ack SHALL each be registered once; an event is the input high while its registered copy is low.
- REQ-013 The FSM SHALL have states LOAD_A, LOAD_B, LOAD_OP, EXEC and PRESENT, with state codes 0, 1, 2, 3 and 3 on uio_out[3:2]; res_valid SHALL distinguish EXEC from PRESENT.
- REQ-014 On a strobe event in LOAD_A, the block SHALL capture ui_in into alu_a and go to LOAD_B.
- REQ-015 On a strobe event in LOAD_B, the block SHALL capture ui_in into alu_b and go to LOAD_OP.
- REQ-016 On a strobe event in LOAD_OP, the block SHALL capture ui_in[1:0] into alu_s and go to EXEC.
- REQ-017 EXEC SHALL last exactly one cycle, then capture alu_result into uo_out and go to PRESENT.
- REQ-018 res_valid SHALL be high from the first cycle after the EXEC cycle through the cycle of the ack event.
- REQ-019 Latency from the op strobe event edge to res_valid high SHALL be 2 clock edges.
- REQ-020 In PRESENT, an ack event SHALL clear res_valid and return the FSM to LOAD_A.
- REQ-021 uo_out SHALL hold the last result until the next EXEC.
- REQ-022 rdy SHALL be high in LOAD_A, LOAD_B and LOAD_OP only.
- REQ-023 Strobe events in EXEC or PRESENT SHALL be discarded, not queued.
- REQ-024 A strobe and an ack event in the same cycle in PRESENT SHALL be resolved as: ack honoured, strobe discarded.
- REQ-025 A strobe held high SHALL produce exactly one event.
- REQ-026 ack outside PRESENT SHALL be ignored.
- REQ-027 The ALU is combinational and instantiated outside this block; alu_result SHALL be sampled only in EXEC.

Reset
- REQ-028 While rst is high, the block SHALL force state to LOAD_A; alu_a, alu_b, alu_s, uo_out, both edge registers and the timeout counter to 0; res_valid to 0; timeout flag to 0.
- REQ-029 Reset asserted mid-transaction SHALL discard all captured bytes; rdy SHALL be 1 in the first cycle after reset release.

Configuration
- REQ-030 When macro ALU_SEQ_TIMEOUT_EN is defined, an 8-bit counter SHALL count cycles with ena high in LOAD_B, LOAD_OP or PRESENT without an event.
- REQ-031 The counter SHALL clear on any accepted event or on a state change.
- REQ-032 When the counter reaches TIMEOUT_CYCLES, the FSM SHALL return to LOAD_A, drop res_valid and set uio_out[4] sticky until the next strobe event.
- REQ-033 Without ALU_SEQ_TIMEOUT_EN, the counter SHALL not exist, uio_out[4] SHALL be 0, and the FSM SHALL wait indefinitely.

Structure
- REQ-034 Package alu_seq_pkg SHALL hold the state enumeration, the uio bit-index constants (STRB_BIT, ACK_BIT, RDY_BIT, VALID_BIT, TO_BIT) and the default TIMEOUT_CYCLES.
- REQ-035 Sub-module alu_seq_edge SHALL provide a registered rising-edge detector, instantiated twice (strobe, ack).

Verification
- REQ-036 The bench ALU model SHALL implement S=00 add, 01 sub, 10 and, 11 or.
- REQ-037 Strobe 0x12, 0x34, 0x00 -> res_valid high 2 edges after the third event, uo_out=0x46, rdy low; then ack -> state LOAD_A, rdy=1.
- REQ-038 Strobe 0x05, 0x07, 0x01 -> uo_out=0xFE (wrap); strobe held high 10 cycles during loading -> only one byte accepted.
- REQ-039 In PRESENT, strobe and ack events in the same cycle -> FSM in LOAD_A, alu_a unchanged from previous value; next strobe 0xAA loads alu_a=0xAA.
- REQ-040 rst pulsed after two bytes -> all outputs 0, uio_oe=0x1F, state code 0; the new three-byte sequence computes correctly.
- REQ-041 ena low for 5 cycles mid-LOAD_B with strobe toggling -> no capture, state unchanged.
- REQ-042 With ALU_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=4 and one byte then idle -> return to LOAD_A after 4 cycles, uio_out[4]=1; the next strobe clears it.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU byte sequencer.
// States, uio bit positions and the default host-idle timeout.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        LOAD_A,
        LOAD_B,
        LOAD_OP,
        EXEC,
        PRESENT
    } state_e;

    localparam int STRB_BIT  = 0;
    localparam int ACK_BIT   = 1;
    localparam int RDY_BIT   = 0;
    localparam int VALID_BIT = 1;
    localparam int TO_BIT    = 4;

    localparam int unsigned DEF_TIMEOUT_CYCLES = 255;

    // EXEC and PRESENT share code 3; res_valid tells them apart.
    function automatic logic [1:0] state_code(input state_e s);
        logic [1:0] c;
        c = 2'd3;
        if (s == LOAD_A)  c = 2'd0;
        if (s == LOAD_B)  c = 2'd1;
        if (s == LOAD_OP) c = 2'd2;
        return c;
    endfunction

endpackage

// File: rtl/alu_seq_edge.sv
// Registered rising-edge detector; the history flop holds while ena is low.
module alu_seq_edge (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic sig,
    output logic rise
);

    logic sig_q;
    logic sig_d;

    always_comb begin
        sig_d = sig_q;
        if (ena) sig_d = sig;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sig_q <= 1'b0;
        else     sig_q <= sig_d;
    end

    assign rise = sig & ~sig_q;

endmodule

// File: rtl/alu_byte_sequencer.sv
// Loads A, B and op bytes from the host, runs one ALU cycle, presents the result.
// Optional host-idle abort is built when ALU_SEQ_TIMEOUT_EN is defined.
module alu_byte_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [1:0] alu_s,
    input  logic [7:0] alu_result
);

    state_e     state_q, state_d, fsm_next;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [1:0] s_q, s_d;
    logic [7:0] res_q, res_d;
    logic       strb_ev, ack_ev;
    logic       rdy, valid, accept, to_flag;
    logic       unused_in;

    alu_seq_edge u_strb_edge (
        .clk  (clk),
        .rst  (rst),
        .ena  (ena),
        .sig  (uio_in[STRB_BIT]),
        .rise (strb_ev)
    );

    alu_seq_edge u_ack_edge (
        .clk  (clk),
        .rst  (rst),
        .ena  (ena),
        .sig  (uio_in[ACK_BIT]),
        .rise (ack_ev)
    );

    assign rdy    = state_q inside {LOAD_A, LOAD_B, LOAD_OP};
    assign valid  = state_q == PRESENT;
    assign accept = (rdy && strb_ev) || (valid && ack_ev);

    always_comb begin
        fsm_next = state_q;
        a_d      = a_q;
        b_d      = b_q;
        s_d      = s_q;
        res_d    = res_q;
        if (ena) begin
            unique case (state_q)
                LOAD_A: if (strb_ev) begin
                    a_d      = ui_in;
                    fsm_next = LOAD_B;
                end
                LOAD_B: if (strb_ev) begin
                    b_d      = ui_in;
                    fsm_next = LOAD_OP;
                end
                LOAD_OP: if (strb_ev) begin
                    s_d      = ui_in[1:0];
                    fsm_next = EXEC;
                end
                EXEC: begin
                    res_d    = alu_result;
                    fsm_next = PRESENT;
                end
                PRESENT: if (ack_ev) fsm_next = LOAD_A;
                default: fsm_next = LOAD_A;
            endcase
        end
    end

`ifdef ALU_SEQ_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       to_q, to_d;
    logic       waiting;

    assign waiting = state_q inside {LOAD_B, LOAD_OP, PRESENT};

    // Timeout overrides the FSM only when no event was accepted.
    always_comb begin
        state_d = fsm_next;
        cnt_d   = cnt_q;
        to_d    = to_q;
        if (ena) begin
            if (strb_ev) to_d = 1'b0;
            if (!waiting || accept) begin
                cnt_d = '0;
            end else if (cnt_q == TO_LAST) begin
                cnt_d   = '0;
                to_d    = 1'b1;
                state_d = LOAD_A;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end

    assign to_flag   = to_q;
    assign unused_in = ^uio_in[7:2];
`else
    assign state_d   = fsm_next;
    assign to_flag   = 1'b0;
    assign unused_in = ^{uio_in[7:2], 8'(TIMEOUT_CYCLES)};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD_A;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        uio_out            = '0;
        uio_out[RDY_BIT]   = rdy;
        uio_out[VALID_BIT] = valid;
        uio_out[3:2]       = state_code(state_q);
        uio_out[TO_BIT]    = to_flag;
    end

    assign uio_oe = 8'h1F;
    assign uo_out = res_q;
    assign alu_a  = a_q;
    assign alu_b  = b_q;
    assign alu_s  = s_q;

endmodule

// File: tb/tb_alu_byte_sequencer.sv
// Directed bench for alu_byte_sequencer with a behavioural ALU.
// Timeout scenario is exercised when ALU_SEQ_TIMEOUT_EN is defined.
module tb_alu_byte_sequencer;

`ifdef ALU_SEQ_TIMEOUT_EN
    localparam int HOLD = 3;
`else
    localparam int HOLD = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic [7:0] ui_in = '0;
    logic       strb = 1'b0;
    logic       ack = 1'b0;
    logic [7:0] uio_in;
    logic [7:0] uo_out, uio_out, uio_oe;
    logic [7:0] alu_a, alu_b, alu_result;
    logic [1:0] alu_s;

    int n_chk  = 0;
    int n_pass = 0;

    assign uio_in = {6'b0, ack, strb};

    always #5 clk = ~clk;

    always_comb begin
        unique case (alu_s)
            2'b00: alu_result = alu_a + alu_b;
            2'b01: alu_result = alu_a - alu_b;
            2'b10: alu_result = alu_a & alu_b;
            default: alu_result = alu_a | alu_b;
        endcase
    end

    alu_byte_sequencer #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .ui_in      (ui_in),
        .uio_in     (uio_in),
        .uo_out     (uo_out),
        .uio_out    (uio_out),
        .uio_oe     (uio_oe),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_s      (alu_s),
        .alu_result (alu_result)
    );

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] v);
        ui_in = v;
        strb  = 1'b1;
        step();
        strb  = 1'b0;
        step();
    endtask

    task automatic take();
        ack = 1'b1;
        step();
        ack = 1'b0;
        step();
    endtask

    initial begin
        step();
        step();
        check("rst_uio_out", uio_out, 8'h01);
        check("rst_uo_out", uo_out, 8'h00);
        check("rst_alu_a", alu_a, 8'h00);
        check("rst_oe", uio_oe, 8'h1F);
        rst = 1'b0;
        step();
        check("post_rst_rdy", uio_out, 8'h01);

        // 0x12 + 0x34, with exact latency
        send(8'h12);
        check("a_cap", alu_a, 8'h12);
        check("st_b", uio_out, 8'h05);
        send(8'h34);
        check("b_cap", alu_b, 8'h34);
        check("st_op", uio_out, 8'h09);
        ui_in = 8'h00;
        strb  = 1'b1;
        step();
        check("exec", uio_out, 8'h0C);
        strb = 1'b0;
        step();
        check("present", uio_out, 8'h0E);
        check("add", uo_out, 8'h46);
        ack = 1'b1;
        step();
        check("ack_back", uio_out, 8'h01);
        ack = 1'b0;
        step();
        check("res_hold", uo_out, 8'h46);

        // held strobe yields a single byte; 5 - 7 wraps
        ui_in = 8'h05;
        strb  = 1'b1;
        step();
        ui_in = 8'h99;
        repeat (HOLD - 1) step();
        check("hold_a", alu_a, 8'h05);
        check("hold_st", uio_out, 8'h05);
        strb = 1'b0;
        step();
        send(8'h07);
        send(8'h01);
        check("sub_wrap", uo_out, 8'hFE);
        take();

        // simultaneous strobe and ack in PRESENT
        send(8'h0F);
        send(8'hF0);
        send(8'h03);
        check("or", uo_out, 8'hFF);
        ui_in = 8'h55;
        strb  = 1'b1;
        ack   = 1'b1;
        step();
        strb = 1'b0;
        ack  = 1'b0;
        step();
        check("both_st", uio_out, 8'h01);
        check("both_a", alu_a, 8'h0F);
        send(8'hAA);
        check("next_a", alu_a, 8'hAA);
        send(8'h0F);
        send(8'h02);
        check("and", uo_out, 8'h0A);
        take();

        // reset mid-transaction
        send(8'h11);
        send(8'h22);
        rst = 1'b1;
        step();
        check("mid_rst_uio", uio_out, 8'h01);
        check("mid_rst_a", alu_a, 8'h00);
        check("mid_rst_b", alu_b, 8'h00);
        check("mid_rst_res", uo_out, 8'h00);
        check("mid_rst_oe", uio_oe, 8'h1F);
        rst = 1'b0;
        step();
        check("mid_rst_rdy", uio_out, 8'h01);
        send(8'h30);
        send(8'h0C);
        send(8'h01);
        check("sub2", uo_out, 8'h24);
        take();

        // ena low freezes everything
        send(8'h40);
        ui_in = 8'h77;
        ena   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            strb = ~strb;
            step();
        end
        strb = 1'b0;
        ena  = 1'b1;
        step();
        check("ena_st", uio_out, 8'h05);
        check("ena_b", alu_b, 8'h0C);
        send(8'h50);
        send(8'h00);
        check("add2", uo_out, 8'h90);
        take();

`ifdef ALU_SEQ_TIMEOUT_EN
        send(8'h01);
        step();
        step();
        check("to_wait", uio_out, 8'h05);
        step();
        check("to_fire", uio_out, 8'h11);
        send(8'h02);
        check("to_clear", uio_out, 8'h05);
        check("to_a", alu_a, 8'h02);
`else
        check("no_to", uio_out, 8'h01);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
